// File: rtl/instr_fetch.sv
// Instruction-fetch front end: one memory read per PC value over req/ack,
// returned {pc, instr} pairs buffered in a small FIFO toward decode.
module instr_fetch #(
  parameter logic [31:0] PC_BEGIN = 32'h0000_3000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic        PC_en,
  input  logic        flush,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_drain_addr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_next;
  logic [31:0]        r_pc_mem    [DEPTH];
  logic [31:0]        r_instr_mem [DEPTH];
  logic               w_push;
  logic               w_pop;
  logic               w_room;

  assign w_push       = (r_state == S_REQ) & im_ack & ~flush;
  assign if_valid     = (r_count != '0) & ~flush;
  assign w_pop        = if_valid & if_ready;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_room       = w_count_next < CNT_W'(DEPTH);

  assign PC_en    = flush | w_push;
  assign im_req   = (r_state == S_REQ) || (r_state == S_DRAIN);
  // DRAIN keeps presenting the abandoned address; PC has already moved to the target
  assign im_addr  = (r_state == S_DRAIN) ? r_drain_addr : PC;
  assign if_pc    = r_pc_mem[r_rd_ptr];
  assign if_instr = r_instr_mem[r_rd_ptr];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!flush && w_room) w_state_next = S_REQ;
      S_REQ: begin
        if (im_ack)     w_state_next = (!flush && w_room) ? S_REQ : S_IDLE;
        else if (flush) w_state_next = S_DRAIN;
      end
      S_DRAIN: if (im_ack) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_drain_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_REQ) && !im_ack && flush) r_drain_addr <= PC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= PC_BEGIN;
        r_instr_mem[i] <= '0;
      end
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]    <= PC;
        r_instr_mem[r_wr_ptr] <= im_rdata;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: surrounding PC register and variable-latency
// instruction memory are modelled here; expectations are hand-computed constants.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC;
  logic        PC_en;
  logic        flush;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic [31:0] tgt;
  int unsigned mem_lat;
  int unsigned wcnt;
  int          n_vec = 0;
  int          n_err = 0;

  instr_fetch #(.PC_BEGIN(32'h0000_3000), .DEPTH(2)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .PC       (PC),
    .PC_en    (PC_en),
    .flush    (flush),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_ack   (im_ack),
    .im_rdata (im_rdata),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_instr (if_instr),
    .if_pc    (if_pc)
  );

  always #5 clk = ~clk;

  // PC register: advances by 4 or loads the redirect target
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     PC <= 32'h0000_3000;
    else if (PC_en) PC <= flush ? tgt : PC + 32'd4;
  end

  // Memory acks after mem_lat wait cycles; instr word = {DEAD, addr[15:0]}
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wcnt <= 0;
    else if (im_req && !im_ack) wcnt <= wcnt + 1;
    else                        wcnt <= 0;
  end

  always_comb begin
    im_ack   = im_req && (wcnt >= mem_lat);
    im_rdata = {16'hDEAD, im_addr[15:0]};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; if_ready = 1'b1; mem_lat = 0; tgt = '0;
    tick();
    tick();
    check("rst im_req",   32'(im_req),   32'd0);
    check("rst PC_en",    32'(PC_en),    32'd0);
    check("rst if_valid", 32'(if_valid), 32'd0);
    check("rst if_pc",    if_pc,         32'h0000_3000);
    check("rst if_instr", if_instr,      32'h0);

    // 1: zero-wait streaming
    rst_n = 1'b1;
    #1 check("t1 idle im_req", 32'(im_req), 32'd0);
    tick();
    check("t1 im_req",   32'(im_req),   32'd1);
    check("t1 im_addr",  im_addr,       32'h0000_3000);
    check("t1 PC_en",    32'(PC_en),    32'd1);
    check("t1 if_valid", 32'(if_valid), 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t1 s if_valid", 32'(if_valid), 32'd1);
      check("t1 s if_pc",    if_pc,         32'h0000_3000 + 32'(4 * k));
      check("t1 s if_instr", if_instr,      32'hDEAD_3000 + 32'(4 * k));
      check("t1 s PC_en",    32'(PC_en),    32'd1);
      tick();
    end

    // 2: backpressure fills exactly DEPTH entries
    if_ready = 1'b0; mem_lat = 0;
    do_reset();
    #1 check("t2 A im_req", 32'(im_req), 32'd0);
    tick();
    check("t2 B PC_en",   32'(PC_en), 32'd1);
    check("t2 B im_addr", im_addr,    32'h0000_3000);
    tick();
    check("t2 C if_pc",   if_pc,      32'h0000_3000);
    check("t2 C PC_en",   32'(PC_en), 32'd1);
    check("t2 C im_addr", im_addr,    32'h0000_3004);
    tick();
    check("t2 D im_req",   32'(im_req),   32'd0);
    check("t2 D PC_en",    32'(PC_en),    32'd0);
    check("t2 D if_valid", 32'(if_valid), 32'd1);
    tick();
    if_ready = 1'b1;
    #1;
    check("t2 E im_req", 32'(im_req), 32'd0);
    check("t2 E PC_en",  32'(PC_en),  32'd0);
    check("t2 E if_pc",  if_pc,       32'h0000_3000);
    tick();
    check("t2 F if_pc",   if_pc,       32'h0000_3004);
    check("t2 F im_req",  32'(im_req), 32'd1);
    check("t2 F im_addr", im_addr,     32'h0000_3008);
    check("t2 F PC_en",   32'(PC_en),  32'd1);
    tick();
    check("t2 G if_pc",    if_pc,    32'h0000_3008);
    check("t2 G if_instr", if_instr, 32'hDEAD_3008);

    // 3: slow memory, ack on third request cycle
    if_ready = 1'b0; mem_lat = 2;
    do_reset();
    tick();
    check("t3 B im_req",  32'(im_req), 32'd1);
    check("t3 B im_addr", im_addr,     32'h0000_3000);
    check("t3 B PC_en",   32'(PC_en),  32'd0);
    tick();
    check("t3 C im_addr", im_addr,     32'h0000_3000);
    check("t3 C PC_en",   32'(PC_en),  32'd0);
    tick();
    check("t3 D im_addr", im_addr,     32'h0000_3000);
    check("t3 D PC_en",   32'(PC_en),  32'd1);
    tick();
    check("t3 E if_valid", 32'(if_valid), 32'd1);
    check("t3 E if_pc",    if_pc,         32'h0000_3000);
    check("t3 E im_addr",  im_addr,       32'h0000_3004);
    check("t3 E PC_en",    32'(PC_en),    32'd0);
    tick();
    check("t3 F if_pc", if_pc,      32'h0000_3000);
    check("t3 F PC_en", 32'(PC_en), 32'd0);

    // 4: flush while a request is pending -> DRAIN
    if_ready = 1'b1; mem_lat = 0;
    do_reset();
    tick();
    tick();
    tick();
    mem_lat = 5; flush = 1'b1; tgt = 32'h0000_3100;
    #1;
    check("t4 D PC_en",    32'(PC_en),    32'd1);
    check("t4 D if_valid", 32'(if_valid), 32'd0);
    check("t4 D im_addr",  im_addr,       32'h0000_3008);
    tick();
    flush = 1'b0;
    #1;
    check("t4 E im_req",   32'(im_req),   32'd1);
    check("t4 E im_addr",  im_addr,       32'h0000_3008);
    check("t4 E if_valid", 32'(if_valid), 32'd0);
    check("t4 E PC_en",    32'(PC_en),    32'd0);
    tick();
    mem_lat = 2;
    #1;
    check("t4 F im_addr", im_addr,    32'h0000_3008);
    check("t4 F PC_en",   32'(PC_en), 32'd0);
    tick();
    mem_lat = 0;
    #1;
    check("t4 G im_req",   32'(im_req),   32'd0);
    check("t4 G if_valid", 32'(if_valid), 32'd0);
    tick();
    check("t4 H im_req",  32'(im_req), 32'd1);
    check("t4 H im_addr", im_addr,     32'h0000_3100);
    check("t4 H PC_en",   32'(PC_en),  32'd1);
    tick();
    check("t4 I if_valid", 32'(if_valid), 32'd1);
    check("t4 I if_pc",    if_pc,         32'h0000_3100);
    check("t4 I if_instr", if_instr,      32'hDEAD_3100);

    // 5: flush coincident with ack and with if_ready
    if_ready = 1'b1; mem_lat = 0;
    do_reset();
    tick();
    tick();
    flush = 1'b1; tgt = 32'h0000_3200;
    #1;
    check("t5 C if_valid", 32'(if_valid), 32'd0);
    check("t5 C PC_en",    32'(PC_en),    32'd1);
    tick();
    flush = 1'b0;
    #1;
    check("t5 D if_valid", 32'(if_valid), 32'd0);
    check("t5 D im_req",   32'(im_req),   32'd0);
    tick();
    check("t5 E im_addr", im_addr, 32'h0000_3200);
    tick();
    check("t5 F if_valid", 32'(if_valid), 32'd1);
    check("t5 F if_pc",    if_pc,         32'h0000_3200);

    // 6: reset during a pending request with data buffered
    if_ready = 1'b0; mem_lat = 0;
    do_reset();
    tick();
    tick();
    mem_lat = 5;
    #1;
    check("t6 C im_req",   32'(im_req), 32'd1);
    check("t6 C im_addr",  im_addr,     32'h0000_3004);
    check("t6 C if_instr", if_instr,    32'hDEAD_3000);
    tick();
    check("t6 D if_valid", 32'(if_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6 R im_req",   32'(im_req),   32'd0);
    check("t6 R if_valid", 32'(if_valid), 32'd0);
    check("t6 R PC_en",    32'(PC_en),    32'd0);
    check("t6 R if_pc",    if_pc,         32'h0000_3000);
    check("t6 R if_instr", if_instr,      32'h0);
    tick();
    mem_lat = 0; if_ready = 1'b1; rst_n = 1'b1;
    #1 check("t6 A im_req", 32'(im_req), 32'd0);
    tick();
    check("t6 B im_addr", im_addr,    32'h0000_3000);
    check("t6 B PC_en",   32'(PC_en), 32'd1);
    tick();
    check("t6 C' if_pc",    if_pc,    32'h0000_3000);
    check("t6 C' if_instr", if_instr, 32'hDEAD_3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
